// File: rtl/neopix_pkg.sv
// rtl/neopix_pkg.sv - shared encodings and sizing helpers for the neopixel frame buffer
package neopix_pkg;

  // Launch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  // Which colour byte of the current pixel arrives next
  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_e;

  // LED address width; a single-LED strip still needs one address bit
  function automatic int addr_width(input int num_leds);
    return (num_leds > 1) ? $clog2(num_leds) : 1;
  endfunction

  // Largest pixel count that still fits in an addr_width-bit count
  function automatic int max_pix(input int num_leds);
    int lim;
    lim = (1 << addr_width(num_leds)) - 1;
    return (num_leds < lim) ? num_leds : lim;
  endfunction

endpackage

// File: rtl/neopix_dpram.sv
// rtl/neopix_dpram.sv - simple dual-port pixel RAM, sync write, registered read
// Ports: clk_i/reset_i clock and sync reset (read register only);
//        we_i/waddr_i/wdata_i write port; re_i/raddr_i/rdata_o read port.
module neopix_dpram #(
  parameter int DW     = 24,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DW-1:0]     rdata_o
);

  logic [DW-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Output register holds the last read until the next request
  always_ff @(posedge clk_i) begin
    if (reset_i)   rdata_o <= '0;
    else if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/neopix_frame_buffer.sv
// rtl/neopix_frame_buffer.sv - double-buffered RGB frame store feeding a ws2812 serializer
// Ports: clk_i/reset_i clock and sync active-high reset;
//        byte_i/byte_valid_i/frame_start_i/frame_end_i SPI-side byte stream;
//        rd_req_i/rd_addr_i -> red_o/green_o/blue_o serializer pixel reads;
//        start_o/led_count_o/busy_i serializer launch handshake;
//        overflow_o sticky flag for bytes dropped beyond the frame capacity.
module neopix_frame_buffer
  import neopix_pkg::*;
#(
  parameter  int NUM_LEDS = 8,
  localparam int AW       = addr_width(NUM_LEDS)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [7:0]    byte_i,
  input  logic          byte_valid_i,
  input  logic          frame_start_i,
  input  logic          frame_end_i,
  input  logic          rd_req_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    red_o,
  output logic [7:0]    green_o,
  output logic [7:0]    blue_o,
  output logic          start_o,
  output logic [AW-1:0] led_count_o,
  input  logic          busy_i,
  output logic          overflow_o
);

  localparam logic [AW-1:0] MAX_PIX_W = AW'(max_pix(NUM_LEDS));

  logic          front;
  logic          in_frame;
  logic [AW-1:0] ptr;
  logic [AW-1:0] pend_count;
  logic          pending;
  phase_e        phase;
  logic [7:0]    r_hold;
  logic [7:0]    g_hold;
  state_e        state;

  logic [AW-1:0] eff_ptr;
  logic [AW-1:0] next_ptr;
  phase_e        eff_phase;
  logic          active;
  logic          at_limit;
  logic          accept;
  logic          wr_en;
  logic          end_ok;
  logic          launch;
  logic [23:0]   rd_data;

  // A same-cycle frame_start takes effect before the byte, and the byte
  // lands before a same-cycle frame_end, so both see these "effective" values.
  always_comb begin
    eff_ptr   = frame_start_i ? '0 : ptr;
    eff_phase = frame_start_i ? PH_R : phase;
    active    = in_frame | frame_start_i;
    at_limit  = (eff_ptr == MAX_PIX_W);
    accept    = active & byte_valid_i & ~at_limit;
    wr_en     = accept & (eff_phase == PH_B);
    next_ptr  = wr_en ? eff_ptr + AW'(1) : eff_ptr;
    end_ok    = active & frame_end_i & (next_ptr != '0);
    // A frame_start in the launch cycle means the pending frame is superseded
    launch    = (state == ST_IDLE) & pending & ~busy_i & ~frame_start_i;
  end

  // Byte assembly into the back bank
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      in_frame   <= 1'b0;
      ptr        <= '0;
      phase      <= PH_R;
      r_hold     <= '0;
      g_hold     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (frame_start_i) overflow_o <= 1'b0;
      if (active & byte_valid_i & at_limit) overflow_o <= 1'b1;
      if (frame_start_i) in_frame <= 1'b1;
      if (frame_end_i)   in_frame <= 1'b0;
      ptr   <= next_ptr;
      phase <= eff_phase;
      if (accept) begin
        case (eff_phase)
          PH_R:    begin r_hold <= byte_i; phase <= PH_G; end
          PH_G:    begin g_hold <= byte_i; phase <= PH_B; end
          default: phase <= PH_R;
        endcase
      end
    end
  end

  // Pending-frame bookkeeping and launch sequencer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      front       <= 1'b0;
      pending     <= 1'b0;
      pend_count  <= '0;
      led_count_o <= '0;
      start_o     <= 1'b0;
    end else begin
      start_o <= 1'b0;
      if (frame_start_i) begin
        pending <= 1'b0;
      end else if (end_ok) begin
        pending    <= 1'b1;
        pend_count <= next_ptr;
      end
      case (state)
        ST_IDLE: begin
          if (launch) begin
            front       <= ~front;
            led_count_o <= pend_count;
            pending     <= 1'b0;
            start_o     <= 1'b1;
            state       <= ST_START;
          end
        end
        ST_START:     state <= ST_WAIT_BUSY;
        // busy_i stays low through the serializer's latch wait; require it
        // to rise before a fall can release the next swap.
        ST_WAIT_BUSY: if (busy_i) state <= ST_RUN;
        ST_RUN:       if (!busy_i) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  neopix_dpram #(
    .DW     (24),
    .ADDR_W (AW + 1)
  ) u_ram (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we_i    (wr_en),
    .waddr_i ({~front, eff_ptr}),
    .wdata_i ({r_hold, g_hold, byte_i}),
    .re_i    (rd_req_i),
    .raddr_i ({front, rd_addr_i}),
    .rdata_o (rd_data)
  );

  assign red_o   = rd_data[23:16];
  assign green_o = rd_data[15:8];
  assign blue_o  = rd_data[7:0];

endmodule

// File: tb/tb_neopix_frame_buffer.sv
// tb/tb_neopix_frame_buffer.sv - scoreboard bench for neopix_frame_buffer
module tb_neopix_frame_buffer;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] byte_i = '0;
  logic       byte_valid_i = 1'b0;
  logic       frame_start_i = 1'b0;
  logic       frame_end_i = 1'b0;
  logic       rd_req_i = 1'b0;
  logic [2:0] rd_addr_i = '0;
  logic [7:0] red_o, green_o, blue_o;
  logic       start_o;
  logic [2:0] led_count_o;
  logic       busy_i = 1'b0;
  logic       overflow_o;

  int checks = 0;
  int passed = 0;
  int start_cnt = 0;

  logic [7:0]  tx   [0:31];
  logic [7:0]  prev [0:31];
  int          tx_n;
  logic [23:0] sb [$];

  neopix_frame_buffer #(.NUM_LEDS(8)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .byte_i        (byte_i),
    .byte_valid_i  (byte_valid_i),
    .frame_start_i (frame_start_i),
    .frame_end_i   (frame_end_i),
    .rd_req_i      (rd_req_i),
    .rd_addr_i     (rd_addr_i),
    .red_o         (red_o),
    .green_o       (green_o),
    .blue_o        (blue_o),
    .start_o       (start_o),
    .led_count_o   (led_count_o),
    .busy_i        (busy_i),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (start_o === 1'b1) start_cnt++;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic build(input int n, input int base, input int step);
    tx_n = n;
    for (int k = 0; k < n; k++) tx[k] = 8'(base + step * k);
  endtask

  task automatic save_prev();
    for (int k = 0; k < 32; k++) prev[k] = tx[k];
  endtask

  function automatic logic [23:0] pix(input int i);
    return {tx[3*i], tx[3*i+1], tx[3*i+2]};
  endfunction

  function automatic logic [23:0] prev_pix(input int i);
    return {prev[3*i], prev[3*i+1], prev[3*i+2]};
  endfunction

  task automatic send_frame();
    frame_start_i = 1'b1; tick(); frame_start_i = 1'b0;
    for (int k = 0; k < tx_n; k++) begin
      byte_valid_i = 1'b1; byte_i = tx[k]; tick();
    end
    byte_valid_i = 1'b0;
    frame_end_i = 1'b1; tick(); frame_end_i = 1'b0;
  endtask

  task automatic wait_start(input int s0, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (start_cnt != s0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // Issues a read and records what the pixel must be when it comes back
  task automatic read_pix(input int addr, input logic [23:0] exp);
    sb.push_back(exp);
    rd_req_i = 1'b1; rd_addr_i = 3'(addr); tick(); rd_req_i = 1'b0;
  endtask

  task automatic serialize();
    busy_i = 1'b1; repeat (5) tick();
    busy_i = 1'b0; repeat (3) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    reset_i = 1'b0; tick();
    checks++; if (start_o !== 1'b0) $display("FAIL reset_start got=%0d exp=0", start_o); else passed++;
    checks++; if (led_count_o !== 3'd0) $display("FAIL reset_count got=%0d exp=0", led_count_o); else passed++;
    checks++; if (overflow_o !== 1'b0) $display("FAIL reset_ovf got=%0d exp=0", overflow_o); else passed++;
    checks++; if ({red_o, green_o, blue_o} !== 24'h0) $display("FAIL reset_rgb got=%h exp=0", {red_o, green_o, blue_o}); else passed++;
  endtask

  task automatic test_basic();
    int s0; bit ok; logic [23:0] e;
    s0 = start_cnt;
    build(9, 11, 11);
    send_frame();
    wait_start(s0, ok);
    checks++; if (!ok) $display("FAIL basic_start_timeout got=none exp=pulse"); else passed++;
    repeat (5) tick();
    checks++; if (start_cnt - s0 !== 1) $display("FAIL basic_start_count got=%0d exp=1", start_cnt - s0); else passed++;
    checks++; if (led_count_o !== 3'd3) $display("FAIL basic_count got=%0d exp=3", led_count_o); else passed++;
    read_pix(2, {8'd77, 8'd88, 8'd99});
    e = sb.pop_front();
    checks++; if ({red_o, green_o, blue_o} !== e) $display("FAIL basic_rd2 got=%h exp=%h", {red_o, green_o, blue_o}, e); else passed++;
    tick();
    checks++; if ({red_o, green_o, blue_o} !== e) $display("FAIL basic_hold got=%h exp=%h", {red_o, green_o, blue_o}, e); else passed++;
    read_pix(0, {8'd11, 8'd22, 8'd33});
    e = sb.pop_front();
    checks++; if ({red_o, green_o, blue_o} !== e) $display("FAIL basic_rd0 got=%h exp=%h", {red_o, green_o, blue_o}, e); else passed++;
    serialize();
  endtask

  task automatic test_partial();
    int s0; bit ok; logic [23:0] e;
    s0 = start_cnt;
    build(7, 11, 11);
    send_frame();
    wait_start(s0, ok);
    checks++; if (!ok) $display("FAIL partial_start_timeout got=none exp=pulse"); else passed++;
    checks++; if (led_count_o !== 3'd2) $display("FAIL partial_count got=%0d exp=2", led_count_o); else passed++;
    checks++; if (overflow_o !== 1'b0) $display("FAIL partial_ovf got=%0d exp=0", overflow_o); else passed++;
    read_pix(1, {8'd44, 8'd55, 8'd66});
    e = sb.pop_front();
    checks++; if ({red_o, green_o, blue_o} !== e) $display("FAIL partial_rd1 got=%h exp=%h", {red_o, green_o, blue_o}, e); else passed++;
    serialize();
  endtask

  task automatic test_overflow_and_empty();
    int s0; bit ok; logic [23:0] e;
    s0 = start_cnt;
    build(24, 8'h40, 3);
    send_frame();
    checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_set got=%0d exp=1", overflow_o); else passed++;
    wait_start(s0, ok);
    checks++; if (!ok) $display("FAIL ovf_start_timeout got=none exp=pulse"); else passed++;
    checks++; if (led_count_o !== 3'd7) $display("FAIL ovf_count got=%0d exp=7", led_count_o); else passed++;
    read_pix(6, pix(6));
    e = sb.pop_front();
    checks++; if ({red_o, green_o, blue_o} !== e) $display("FAIL ovf_rd6 got=%h exp=%h", {red_o, green_o, blue_o}, e); else passed++;
    serialize();
    s0 = start_cnt;
    frame_start_i = 1'b1; tick(); frame_start_i = 1'b0;
    checks++; if (overflow_o !== 1'b0) $display("FAIL ovf_clear got=%0d exp=0", overflow_o); else passed++;
    frame_end_i = 1'b1; tick(); frame_end_i = 1'b0;
    repeat (10) tick();
    checks++; if (start_cnt !== s0) $display("FAIL empty_no_start got=%0d exp=%0d", start_cnt, s0); else passed++;
  endtask

  task automatic test_busy_defer();
    int s0; bit ok; logic [23:0] e;
    s0 = start_cnt;
    build(6, 8'h10, 5);
    send_frame();
    wait_start(s0, ok);
    save_prev();
    busy_i = 1'b1; repeat (2) tick();
    s0 = start_cnt;
    build(12, 8'hA0, 7);
    send_frame();
    repeat (10) tick();
    checks++; if (start_cnt !== s0) $display("FAIL defer_no_start got=%0d exp=%0d", start_cnt, s0); else passed++;
    read_pix(1, prev_pix(1));
    e = sb.pop_front();
    checks++; if ({red_o, green_o, blue_o} !== e) $display("FAIL defer_old_data got=%h exp=%h", {red_o, green_o, blue_o}, e); else passed++;
    busy_i = 1'b0;
    wait_start(s0, ok);
    checks++; if (!ok) $display("FAIL defer_start_timeout got=none exp=pulse"); else passed++;
    repeat (10) tick();
    checks++; if (start_cnt - s0 !== 1) $display("FAIL defer_start_count got=%0d exp=1", start_cnt - s0); else passed++;
    checks++; if (led_count_o !== 3'd4) $display("FAIL defer_count got=%0d exp=4", led_count_o); else passed++;
    for (int i = 0; i < 4; i++) begin
      read_pix(i, pix(i));
      e = sb.pop_front();
      checks++; if ({red_o, green_o, blue_o} !== e) $display("FAIL defer_new_rd%0d got=%h exp=%h", i, {red_o, green_o, blue_o}, e); else passed++;
    end
    serialize();
  endtask

  task automatic test_latest_wins();
    int s0; bit ok; logic [23:0] e;
    s0 = start_cnt;
    build(3, 8'h21, 1);
    send_frame();
    wait_start(s0, ok);
    busy_i = 1'b1; repeat (2) tick();
    s0 = start_cnt;
    build(15, 8'h55, 2);
    send_frame();
    build(8, 8'hC3, 9);
    send_frame();
    busy_i = 1'b0;
    wait_start(s0, ok);
    checks++; if (!ok) $display("FAIL latest_start_timeout got=none exp=pulse"); else passed++;
    repeat (10) tick();
    checks++; if (start_cnt - s0 !== 1) $display("FAIL latest_start_count got=%0d exp=1", start_cnt - s0); else passed++;
    checks++; if (led_count_o !== 3'd2) $display("FAIL latest_count got=%0d exp=2", led_count_o); else passed++;
    read_pix(1, pix(1));
    e = sb.pop_front();
    checks++; if ({red_o, green_o, blue_o} !== e) $display("FAIL latest_rd1 got=%h exp=%h", {red_o, green_o, blue_o}, e); else passed++;
    serialize();
  endtask

  task automatic test_reset_wait_busy();
    int s0; bit ok; logic [23:0] e;
    s0 = start_cnt;
    build(3, 8'hE1, 4);
    send_frame();
    wait_start(s0, ok);
    checks++; if (!ok) $display("FAIL rstwb_start_timeout got=none exp=pulse"); else passed++;
    read_pix(0, pix(0));
    e = sb.pop_front();
    checks++; if ({red_o, green_o, blue_o} !== e) $display("FAIL rstwb_rd0 got=%h exp=%h", {red_o, green_o, blue_o}, e); else passed++;
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    s0 = start_cnt;
    checks++; if (led_count_o !== 3'd0) $display("FAIL rstwb_count got=%0d exp=0", led_count_o); else passed++;
    checks++; if (start_o !== 1'b0) $display("FAIL rstwb_start got=%0d exp=0", start_o); else passed++;
    checks++; if ({red_o, green_o, blue_o} !== 24'h0) $display("FAIL rstwb_rgb got=%h exp=0", {red_o, green_o, blue_o}); else passed++;
    frame_end_i = 1'b1; tick(); frame_end_i = 1'b0;
    repeat (15) tick();
    checks++; if (start_cnt !== s0) $display("FAIL rstwb_no_start got=%0d exp=%0d", start_cnt, s0); else passed++;
    // FSM must be back in IDLE: a fresh frame launches with busy low
    build(3, 8'h31, 1);
    send_frame();
    wait_start(s0, ok);
    checks++; if (!ok) $display("FAIL rstwb_idle_launch got=none exp=pulse"); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_overflow_and_empty();
    test_busy_defer();
    test_latest_wins();
    test_reset_wait_busy();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/neopix_frame_buffer.md
Name: neopix_frame_buffer

Overview:
- Double-buffered pixel store between the SPI byte receiver (upstream) and the ws2812 serializer (downstream).
- Assembles an incoming R,G,B byte stream into 24-bit pixels in a back bank.
- On a valid frame end, swaps banks once the serializer is idle, then pulses the serializer start with the frame's LED count.
- Serves the serializer's read requests from the front bank with one-cycle latency.

Parameters:
- NUM_LEDS, 8: RAM depth per bank. AW = $clog2(NUM_LEDS).
- MAX_PIX, derived: min(NUM_LEDS, 2**AW-1). Highest pixel count per frame; must be representable in led_count_o.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- byte_i  in  8  received SPI byte.
- byte_valid_i  in  1  byte_i valid, one-cycle strobe.
- frame_start_i  in  1  chip-select asserted, one-cycle strobe.
- frame_end_i  in  1  chip-select released, one-cycle strobe.
- rd_req_i  in  1  serializer data request.
- rd_addr_i  in  AW  serializer LED address.
- red_o  out  8  pixel red for last request.
- green_o  out  8  pixel green for last request.
- blue_o  out  8  pixel blue for last request.
- start_o  out  1  one-cycle start pulse to serializer.
- led_count_o  out  AW  pixel count of front frame.
- busy_i  in  1  serializer busy.
- overflow_o  out  1  sticky: bytes dropped beyond MAX_PIX in current frame.

Behaviour:
Reset:
- All outputs 0; front bank = 0; write pointer 0; byte phase R; no pending frame; FSM IDLE.
- Reset mid-frame or mid-launch discards everything. RAM contents are not cleared.

Write side (back bank = ~front):
- frame_start_i: pointer <= 0, phase <= R, overflow_o <= 0, pending <= 0. Latest frame wins; an unswapped pending frame is discarded.
- byte_valid_i with phase R or G: capture byte into holding register, advance phase.
- byte_valid_i with phase B: write {R,G,B} to RAM[{back,pointer}], pointer+1, phase <= R.
- Pointer == MAX_PIX: bytes ignored, overflow_o <= 1.
- Same-cycle frame_start_i and byte_valid_i: start applies first; the byte is byte 0 of the new frame.
- Same-cycle byte_valid_i and frame_end_i: the byte is processed first, then the end.
- frame_end_i with pointer >= 1: pending <= 1, pend_count <= pointer. A trailing partial pixel (phase != R) is dropped.
- frame_end_i with pointer == 0: ignored, because the serializer cannot send a zero count.
- Bytes outside a frame (after end, before start) are ignored.

Launch FSM:
- IDLE: if pending and !busy_i: front <= back, led_count_o <= pend_count, pending <= 0 -> START.
- START: start_o = 1 for exactly this cycle -> WAIT_BUSY.
- WAIT_BUSY: wait for busy_i == 1 -> RUN. This stops a second swap during the serializer's reset/latch wait, when busy_i is still low.
- RUN: wait for busy_i == 0 -> IDLE.
- A frame completing during START/WAIT_BUSY/RUN stays pending and launches on return to IDLE.

Read side:
- rd_req_i high in cycle t: {red_o,green_o,blue_o} <= RAM[{front,rd_addr_i}], valid from cycle t+1 and held until the next request.
- rd_addr_i >= led_count_o returns RAM contents unchecked; this is not an error.

Width:
- The pointer saturates and never wraps.
- The swap uses the bank index toggle only; there is no copying.

Decomposition:
- Package neopix_pkg: FSM state encodings (IDLE, START, WAIT_BUSY, RUN) and byte-phase encodings (R, G, B).
- One sub-module, neopix_dpram: simple dual-port RAM, 2*NUM_LEDS x 24, synchronous write and registered read, inferable as block RAM.

Test Plan:
- Frame start, 9 bytes 11,22,33,44,55,66,77,88,99, frame end, busy_i low -> one start_o pulse, led_count_o=3; rd_addr 2 gives R=77 G=88 B=99 one cycle after rd_req.
- Frame of 7 bytes -> led_count_o=2; last byte dropped; no overflow.
- NUM_LEDS=8: send 8 pixels -> led_count_o=7, overflow_o=1. Next frame_start clears overflow_o.
- Frame B ends while busy_i high after frame A's launch -> no start_o until busy_i falls. Then exactly one start_o, and reads return frame B data while frame A data stays intact until the swap.
- Two frames end before busy_i falls; second frame_start arrives before the swap -> only the second frame launches.
- Empty frame (start then end) -> no start_o. Reset asserted in WAIT_BUSY -> all outputs 0, FSM IDLE, no further start_o.
